// File: rtl/servo_sweep_multi.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : servo_sweep_multi
// Brief    : Multi-channel servo PWM with a shared frame counter; each channel
//            sweeps between limits or slews at a bounded rate toward a target.
// Revision : 1.0 - initial release
// ============================================================================
module servo_sweep_multi #(
    parameter  int NUM_CH         = 2,
    parameter  int CLKS_PER_FRAME = 500000,
    parameter  int MIN_PULSE      = 25000,
    parameter  int MAX_PULSE      = 50000,
    parameter  int STEP           = 1000,
    localparam int CW             = $clog2(CLKS_PER_FRAME),
    localparam int CHW            = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              i_Clk,
    input  logic              i_Reset,
    input  logic [NUM_CH-1:0] i_Mode,
    input  logic              i_Wr_En,
    input  logic [CHW-1:0]    i_Wr_Ch,
    input  logic [CW-1:0]     i_Wr_Pos,
    output logic [NUM_CH-1:0] o_Servo,
    output logic [NUM_CH-1:0] o_Dir,
    output logic              o_Frame
);

    localparam int            CW1      = CW + 1;
    localparam logic [CW-1:0] c_LAST   = CW'(CLKS_PER_FRAME - 1);
    localparam logic [CW-1:0] c_MIN    = CW'(MIN_PULSE);
    localparam logic [CW-1:0] c_MAX    = CW'(MAX_PULSE);
    localparam logic [CW:0]   c_MIN_X  = CW1'(MIN_PULSE);
    localparam logic [CW:0]   c_MAX_X  = CW1'(MAX_PULSE);
    localparam logic [CW:0]   c_STEP_X = CW1'(STEP);

    logic [CW-1:0]     r_cnt;
    logic [CW-1:0]     r_w     [NUM_CH];
    logic [CW-1:0]     r_t     [NUM_CH];
    logic [NUM_CH-1:0] r_d;
    logic [NUM_CH-1:0] r_servo;
    logic              r_frame;

    logic              w_upd;
    logic [CW-1:0]     w_wr_pos;
    logic [CW-1:0]     w_w_nxt [NUM_CH];
    logic [NUM_CH-1:0] w_d_nxt;
    logic [CW:0]       w_wx    [NUM_CH];
    logic [CW:0]       w_tx    [NUM_CH];
    logic [CW:0]       w_diff  [NUM_CH];

    assign w_upd    = (r_cnt == c_LAST);
    assign w_wr_pos = (i_Wr_Pos < c_MIN) ? c_MIN :
                      (i_Wr_Pos > c_MAX) ? c_MAX : i_Wr_Pos;

    // Next width/direction, computed one bit wider so sweep limits never wrap
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            w_wx[i]    = {1'b0, r_w[i]};
            w_tx[i]    = {1'b0, r_t[i]};
            w_diff[i]  = (r_t[i] > r_w[i]) ? (w_tx[i] - w_wx[i]) : (w_wx[i] - w_tx[i]);
            w_w_nxt[i] = r_w[i];
            w_d_nxt[i] = r_d[i];
            if (!i_Mode[i]) begin
                if (r_d[i]) begin
                    if (w_wx[i] + c_STEP_X >= c_MAX_X) begin
                        w_w_nxt[i] = c_MAX;
                        w_d_nxt[i] = 1'b0;
                    end else begin
                        w_w_nxt[i] = CW'(w_wx[i] + c_STEP_X);
                    end
                end else begin
                    if (w_wx[i] <= c_MIN_X + c_STEP_X) begin
                        w_w_nxt[i] = c_MIN;
                        w_d_nxt[i] = 1'b1;
                    end else begin
                        w_w_nxt[i] = CW'(w_wx[i] - c_STEP_X);
                    end
                end
            end else if (r_t[i] != r_w[i]) begin
                w_d_nxt[i] = (r_t[i] > r_w[i]);
                if (w_diff[i] <= c_STEP_X) begin
                    w_w_nxt[i] = r_t[i];
                end else if (r_t[i] > r_w[i]) begin
                    w_w_nxt[i] = CW'(w_wx[i] + c_STEP_X);
                end else begin
                    w_w_nxt[i] = CW'(w_wx[i] - c_STEP_X);
                end
            end
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            r_cnt   <= '0;
            r_d     <= '1;
            r_servo <= '0;
            r_frame <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                r_w[i] <= c_MIN;
                r_t[i] <= c_MIN;
            end
        end else begin
            r_cnt   <= w_upd ? '0 : r_cnt + 1'b1;
            r_frame <= (r_cnt == '0);
            for (int i = 0; i < NUM_CH; i++) begin
                r_servo[i] <= (r_cnt < r_w[i]);
                if (w_upd) begin
                    r_w[i] <= w_w_nxt[i];
                    r_d[i] <= w_d_nxt[i];
                end
                // An out-of-range channel index matches no channel
                if (i_Wr_En && (i_Wr_Ch == CHW'(i))) begin
                    r_t[i] <= w_wr_pos;
                end
            end
        end
    end

    assign o_Servo = r_servo;
    assign o_Dir   = r_d;
    assign o_Frame = r_frame;

endmodule
`default_nettype wire

// File: tb/tb_servo_sweep_multi.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_servo_sweep_multi
// Brief    : Self-checking bench: per-frame vector table plus hand sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_servo_sweep_multi;

    localparam int FR = 100;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst     = 1'b1;
    logic [1:0] mode    = 2'b00;
    logic       wr_en   = 1'b0;
    logic       wr_ch   = 1'b0;
    logic [6:0] wr_pos  = '0;
    logic [1:0] servo, dir;
    logic       frame;

    logic [2:0] mode3   = 3'b111;
    logic       wr_en3  = 1'b0;
    logic [1:0] wr_ch3  = 2'd0;
    logic [6:0] wr_pos3 = '0;
    logic [2:0] servo3, dir3;
    logic       frame3;

    servo_sweep_multi #(
        .NUM_CH(2), .CLKS_PER_FRAME(FR), .MIN_PULSE(10), .MAX_PULSE(40), .STEP(7)
    ) u_dut (
        .i_Clk(clk), .i_Reset(rst), .i_Mode(mode), .i_Wr_En(wr_en),
        .i_Wr_Ch(wr_ch), .i_Wr_Pos(wr_pos),
        .o_Servo(servo), .o_Dir(dir), .o_Frame(frame)
    );

    // Three-channel copy so that a channel index beyond NUM_CH is representable
    servo_sweep_multi #(
        .NUM_CH(3), .CLKS_PER_FRAME(FR), .MIN_PULSE(10), .MAX_PULSE(40), .STEP(7)
    ) u_dut3 (
        .i_Clk(clk), .i_Reset(rst), .i_Mode(mode3), .i_Wr_En(wr_en3),
        .i_Wr_Ch(wr_ch3), .i_Wr_Pos(wr_pos3),
        .o_Servo(servo3), .o_Dir(dir3), .o_Frame(frame3)
    );

    typedef struct {
        bit         rst;
        logic [1:0] mode;
        int         wr_idx;
        logic       wr_ch;
        logic [6:0] wr_pos;
        int         tg_lo;
        int         tg_hi;
        logic [1:0] tg_mode;
        int         e0;
        int         e1;
        logic [1:0] ed;
    } vec_t;

    vec_t tbl [33];
    int   total = 0;
    int   bad   = 0;

    function automatic vec_t mk(input bit r, input logic [1:0] m, input int wi,
                                input logic wc, input logic [6:0] wp,
                                input int tl, input int th, input logic [1:0] tm,
                                input int e0, input int e1, input logic [1:0] ed);
        vec_t v;
        v.rst = r; v.mode = m; v.wr_idx = wi; v.wr_ch = wc; v.wr_pos = wp;
        v.tg_lo = tl; v.tg_hi = th; v.tg_mode = tm;
        v.e0 = e0; v.e1 = e1; v.ed = ed;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) @(negedge clk);
        chk("rst_servo", servo, 0);
        chk("rst_dir", dir, 3);
        chk("rst_frame", frame, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_frame", frame, 1);
        chk("post_rst_servo", servo, 3);
    endtask

    // Sample one output frame starting at the o_Frame pulse; j indexes cycles
    task automatic run_frame(input vec_t v, output int n0, output int n1,
                             output logic [1:0] d0, output int wrap);
        int         guard;
        logic [1:0] keep;
        guard = 0;
        while (!frame && guard < 3 * FR) begin
            @(negedge clk);
            guard++;
        end
        chk("frame_start", frame, 1);
        n0 = 0; n1 = 0; wrap = 0;
        d0 = dir;
        keep = mode;
        for (int j = 0; j < FR; j++) begin
            n0 += int'(servo[0]);
            n1 += int'(servo[1]);
            if (j == FR - 1) wrap = int'(servo);
            wr_en  = (j == v.wr_idx);
            wr_ch  = v.wr_ch;
            wr_pos = v.wr_pos;
            if (j == v.tg_lo) mode = v.tg_mode;
            if (j == v.tg_hi) mode = keep;
            @(negedge clk);
        end
        wr_en = 1'b0;
    endtask

    task automatic run3(input bit do_wr, input logic [1:0] ch, input logic [6:0] pos,
                        output int n0, output int n1, output int n2);
        int guard;
        guard = 0;
        while (!frame3 && guard < 3 * FR) begin
            @(negedge clk);
            guard++;
        end
        chk("frame3_start", frame3, 1);
        n0 = 0; n1 = 0; n2 = 0;
        for (int j = 0; j < FR; j++) begin
            n0 += int'(servo3[0]);
            n1 += int'(servo3[1]);
            n2 += int'(servo3[2]);
            wr_en3  = do_wr && (j == 0);
            wr_ch3  = ch;
            wr_pos3 = pos;
            @(negedge clk);
        end
        wr_en3 = 1'b0;
    endtask

    initial begin
        vec_t       nv;
        int         a0, a1, a2, wr;
        logic [1:0] ad;

        // rst, mode, wr_idx, wr_ch, wr_pos, tg_lo, tg_hi, tg_mode, exp w0, exp w1, exp dir
        tbl[0]  = mk(1, 2'b00, -1, 0, 0,   -1, -1, 2'b00, 10, 10, 2'b11);
        tbl[1]  = mk(0, 2'b00, -1, 0, 0,   -1, -1, 2'b00, 17, 17, 2'b11);
        tbl[2]  = mk(0, 2'b00, -1, 0, 0,   -1, -1, 2'b00, 24, 24, 2'b11);
        tbl[3]  = mk(0, 2'b00, -1, 0, 0,   -1, -1, 2'b00, 31, 31, 2'b11);
        tbl[4]  = mk(0, 2'b00, -1, 0, 0,   -1, -1, 2'b00, 38, 38, 2'b11);
        tbl[5]  = mk(0, 2'b00, -1, 0, 0,   -1, -1, 2'b00, 40, 40, 2'b00);
        tbl[6]  = mk(0, 2'b00, -1, 0, 0,   -1, -1, 2'b00, 33, 33, 2'b00);
        tbl[7]  = mk(0, 2'b00, -1, 0, 0,   -1, -1, 2'b00, 26, 26, 2'b00);
        tbl[8]  = mk(0, 2'b00, -1, 0, 0,   -1, -1, 2'b00, 19, 19, 2'b00);
        tbl[9]  = mk(0, 2'b00, -1, 0, 0,   -1, -1, 2'b00, 12, 12, 2'b00);
        tbl[10] = mk(0, 2'b00, -1, 0, 0,   -1, -1, 2'b00, 10, 10, 2'b11);
        tbl[11] = mk(0, 2'b00, -1, 0, 0,   -1, -1, 2'b00, 17, 17, 2'b11);
        // slew on ch1 while ch0 keeps sweeping
        tbl[12] = mk(1, 2'b10,  0, 1, 25,  -1, -1, 2'b00, 10, 10, 2'b11);
        tbl[13] = mk(0, 2'b10, -1, 0, 0,   -1, -1, 2'b00, 17, 17, 2'b11);
        tbl[14] = mk(0, 2'b10, -1, 0, 0,   -1, -1, 2'b00, 24, 24, 2'b11);
        tbl[15] = mk(0, 2'b10,  0, 1, 11,  -1, -1, 2'b00, 31, 25, 2'b11);
        tbl[16] = mk(0, 2'b10, -1, 0, 0,   -1, -1, 2'b00, 38, 18, 2'b01);
        tbl[17] = mk(0, 2'b10, -1, 0, 0,   -1, -1, 2'b00, 40, 11, 2'b00);
        // target clamping: 5 -> 10, 120 -> 40
        tbl[18] = mk(0, 2'b10,  0, 1, 5,   -1, -1, 2'b00, 33, 11, 2'b00);
        tbl[19] = mk(0, 2'b10,  0, 1, 120, -1, -1, 2'b00, 26, 10, 2'b00);
        tbl[20] = mk(0, 2'b10, -1, 0, 0,   -1, -1, 2'b00, 19, 17, 2'b10);
        tbl[21] = mk(0, 2'b10, -1, 0, 0,   -1, -1, 2'b00, 12, 24, 2'b10);
        tbl[22] = mk(0, 2'b10, -1, 0, 0,   -1, -1, 2'b00, 10, 31, 2'b11);
        tbl[23] = mk(0, 2'b10, -1, 0, 0,   -1, -1, 2'b00, 17, 38, 2'b11);
        tbl[24] = mk(0, 2'b10, -1, 0, 0,   -1, -1, 2'b00, 24, 40, 2'b11);
        // write on the update cycle (cnt==99), then mid-frame mode glitch
        tbl[25] = mk(0, 2'b10, 98, 1, 25,  -1, -1, 2'b00, 31, 40, 2'b11);
        tbl[26] = mk(0, 2'b10, -1, 0, 0,   49, 59, 2'b01, 38, 40, 2'b11);
        tbl[27] = mk(0, 2'b10, -1, 0, 0,   -1, -1, 2'b00, 40, 33, 2'b00);
        tbl[28] = mk(0, 2'b10, -1, 0, 0,   -1, -1, 2'b00, 33, 26, 2'b00);
        // hold -> sweep on ch1 at W=25, D=0
        tbl[29] = mk(0, 2'b00, -1, 0, 0,   -1, -1, 2'b00, 26, 25, 2'b00);
        tbl[30] = mk(0, 2'b00, -1, 0, 0,   -1, -1, 2'b00, 19, 18, 2'b00);
        tbl[31] = mk(0, 2'b00, -1, 0, 0,   -1, -1, 2'b00, 12, 11, 2'b00);
        tbl[32] = mk(0, 2'b00, -1, 0, 0,   -1, -1, 2'b00, 10, 10, 2'b11);

        for (int r = 0; r < 33; r++) begin
            mode = tbl[r].mode;
            if (tbl[r].rst) do_reset(3);
            run_frame(tbl[r], a0, a1, ad, wr);
            chk($sformatf("r%0d_w0", r), a0, tbl[r].e0);
            chk($sformatf("r%0d_w1", r), a1, tbl[r].e1);
            chk($sformatf("r%0d_dir", r), int'(ad), int'(tbl[r].ed));
            chk($sformatf("r%0d_wrap", r), wr, 0);
        end

        // Reset in the middle of a 17-cycle pulse on ch0
        nv = mk(0, 2'b00, -1, 0, 0, -1, -1, 2'b00, 0, 0, 2'b00);
        chk("mid_frame_start", frame, 1);
        repeat (4) @(negedge clk);
        chk("mid_pre_servo0", int'(servo[0]), 1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_servo", servo, 0);
        chk("mid_rst_frame", frame, 0);
        do_reset(2);
        run_frame(nv, a0, a1, ad, wr);
        chk("mid_after_w0", a0, 10);
        chk("mid_after_w1", a1, 10);
        run_frame(nv, a0, a1, ad, wr);
        chk("mid_next_w0", a0, 17);
        chk("mid_next_w1", a1, 17);

        // Out-of-range channel index on the three-channel instance
        run3(1'b1, 2'd3, 7'd30, a0, a1, a2);
        run3(1'b0, 2'd0, 7'd0,  a0, a1, a2);
        chk("inv_w0", a0, 10);
        chk("inv_w1", a1, 10);
        chk("inv_w2", a2, 10);
        run3(1'b1, 2'd2, 7'd30, a0, a1, a2);
        run3(1'b0, 2'd0, 7'd0,  a0, a1, a2);
        chk("val_w0", a0, 10);
        chk("val_w1", a1, 10);
        chk("val_w2", a2, 17);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
